// File: rtl/seven_seg_scan_pkg.sv
// Shared definitions for the seven-segment scan driver: segment patterns,
// BCD digit width and a helper that picks one digit out of a packed vector.
package seven_seg_scan_pkg;

  localparam int BCD_W   = 4;  // bits per packed BCD digit
  localparam int MAX_DIG = 8;  // widest supported display

  typedef logic [6:0] seg_t;   // seg[0]=a ... seg[6]=g, active-high

  localparam seg_t SEG_0    = 7'h3F;  // a b c d e f
  localparam seg_t SEG_1    = 7'h06;  // b c
  localparam seg_t SEG_2    = 7'h5B;  // a b d e g
  localparam seg_t SEG_3    = 7'h4F;  // a b c d g
  localparam seg_t SEG_4    = 7'h66;  // b c f g
  localparam seg_t SEG_5    = 7'h6D;  // a c d f g
  localparam seg_t SEG_6    = 7'h7D;  // a c d e f g
  localparam seg_t SEG_7    = 7'h07;  // a b c
  localparam seg_t SEG_8    = 7'h7F;  // all
  localparam seg_t SEG_9    = 7'h6F;  // a b c d f g
  localparam seg_t SEG_DASH = 7'h40;  // g only, shown for codes 10..15
  localparam seg_t SEG_OFF  = 7'h00;

  // Digit i of a packed BCD vector (digit 0 in the low nibble).
  function automatic logic [BCD_W-1:0] digit_at(
    input logic [BCD_W*MAX_DIG-1:0] packed_digits,
    input int unsigned              i
  );
    return packed_digits[i*BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display-side bundle: BCD digits and controls in, scanned segment/anode
// drive out. The driver sits on the slave side.
interface seven_seg_scan_if
  import seven_seg_scan_pkg::*;
#(
  parameter int NDIG = 4
);
  logic [BCD_W*NDIG-1:0] digits_in;
  logic                  sec_tick;
  logic                  blank_lz;
  seg_t                  seg;
  logic                  dp;
  logic [NDIG-1:0]       an;

  modport master (output digits_in, sec_tick, blank_lz, input seg, dp, an);
  modport slave  (input digits_in, sec_tick, blank_lz, output seg, dp, an);
endinterface

// File: rtl/seven_seg_scan_bcd_to_seg.sv
// Combinational BCD to active-high seven-segment decoder; codes above 9
// show a dash so a corrupted counter is visible rather than silent.
module bcd_to_seg
  import seven_seg_scan_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output seg_t             o_seg
);

  // Decode one digit to its segment set.
  always_comb begin
    // NOTE: assign a default before the case so every path drives o_seg and no latch is inferred.
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver. Each digit owns a slot of
// REFRESH_DIV cycles whose first cycle is dead time; all digits of one frame
// come from a snapshot taken at the start of the frame.
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 1000,
  parameter bit ACTIVE_LOW  = 1'b1
)(
  input  logic                  clk,
  input  logic                  rst,   // synchronous, active-low
  seven_seg_scan_if.slave       bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NDIG);

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [BCD_W*NDIG-1:0] r_frame;
  logic                  r_blink;
  seg_t                  r_seg;
  logic                  r_dp;
  logic [NDIG-1:0]       r_an;

  logic                     w_cnt_wrap;
  logic                     w_idx_last;
  logic                     w_slot_active;
  logic                     w_snapshot;
  logic [31:0]              w_idx32;
  logic [BCD_W*MAX_DIG-1:0] w_frame_ext;
  logic [BCD_W*NDIG-1:0]    w_upper;
  logic [BCD_W-1:0]         w_digit;
  logic                     w_blank;
  seg_t                     w_seg_raw;
  seg_t                     w_seg_lit;
  logic                     w_dp_lit;
  logic [NDIG-1:0]          w_an_lit;

  assign w_cnt_wrap    = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_idx_last    = (r_idx == IDX_W'(NDIG - 1));
  assign w_slot_active = (r_cnt != '0);
  assign w_snapshot    = (r_cnt == '0) && (r_idx == '0);
  assign w_idx32       = {{(32 - IDX_W){1'b0}}, r_idx};

  // Slot counter and digit index; a wrap of the slot moves to the next digit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_cnt_wrap) begin
      r_cnt <= '0;
      r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Frame snapshot taken in the dead cycle before digit 0, so a frame never mixes old and new digits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame <= '0;
    end else if (w_snapshot) begin
      r_frame <= bus.digits_in;
    end
  end

  // Separator blink state, one toggle per second tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_blink <= 1'b0;
    end else if (bus.sec_tick) begin
      r_blink <= ~r_blink;
    end
  end

  // Widen the frame so the shared digit helper can index it.
  always_comb begin
    w_frame_ext                   = '0;
    w_frame_ext[BCD_W*NDIG-1:0]   = r_frame;
  end

  assign w_digit = digit_at(w_frame_ext, w_idx32);

  // Digits from idx upward are all zero exactly when the shifted frame is zero.
  assign w_upper = r_frame >> (BCD_W * w_idx32);
  assign w_blank = bus.blank_lz && (r_idx != '0) && (w_upper == '0);

  bcd_to_seg u_bcd_to_seg (
    .i_bcd (w_digit),
    .o_seg (w_seg_raw)
  );

  // Logical (active-high) drive for the current slot; dead time leaves everything off.
  always_comb begin
    w_seg_lit = SEG_OFF;
    w_dp_lit  = 1'b0;
    w_an_lit  = '0;
    if (w_slot_active) begin
      w_an_lit[r_idx] = 1'b1;
      if (!w_blank) begin
        w_seg_lit = w_seg_raw;
      end
      w_dp_lit = r_blink && (w_idx32 == 32'd2);
    end
  end

  // Output register applies the display polarity; reset drives the inactive level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_seg <= {7{ACTIVE_LOW}};
      r_dp  <= ACTIVE_LOW;
      r_an  <= {NDIG{ACTIVE_LOW}};
    end else begin
      r_seg <= w_seg_lit ^ {7{ACTIVE_LOW}};
      r_dp  <= w_dp_lit ^ ACTIVE_LOW;
      r_an  <= w_an_lit ^ {NDIG{ACTIVE_LOW}};
    end
  end

  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;
  assign bus.an  = r_an;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with NDIG=4, REFRESH_DIV=4, active-low
// drive. k counts rising edges since reset release; the outputs seen after
// edge k describe scan position k-1, so digit d of frame m is lit for
// k = 16m+4d+2 .. 16m+4d+4 and the snapshot for frame m is taken at edge 16m+1.
module tb_seven_seg_scan;

  localparam int NDIG = 4;
  localparam int RDIV = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   k = 0;

  always #5 clk = ~clk;

  seven_seg_scan_if #(.NDIG(NDIG)) bus ();

  seven_seg_scan #(
    .NDIG        (NDIG),
    .REFRESH_DIV (RDIV),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Active-low segment patterns for 0..9.
  localparam logic [6:0] L0 = 7'h40, L2 = 7'h24, L3 = 7'h30, L4 = 7'h19,
                         L5 = 7'h12, L6 = 7'h02, L7 = 7'h78, L9 = 7'h10;
  localparam logic [6:0] L_DASH = 7'h3F, L_OFF = 7'h7F;

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  task automatic goto(input int t);
    while (k < t) tick();
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    bus.digits_in = 16'h1234;
    bus.blank_lz  = 1'b0;
    bus.sec_tick  = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.an, bus.seg, bus.dp} !== {4'b1111, L_OFF, 1'b1}) begin
        n_errors++;
        $display("FAIL reset_hold[%0d]: an=%b seg=%h dp=%b, expected an=1111 seg=7f dp=1", i, bus.an, bus.seg, bus.dp);
      end
    end
    rst = 1'b1;
    k = 0;
    tick();
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1111, L_OFF}) begin
      n_errors++;
      $display("FAIL release_dead: an=%b seg=%h, expected an=1111 seg=7f", bus.an, bus.seg);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.an, bus.seg, bus.dp} !== {4'b1110, L4, 1'b1}) begin
        n_errors++;
        $display("FAIL release_digit0[%0d]: an=%b seg=%h dp=%b, expected an=1110 seg=%h dp=1", i, bus.an, bus.seg, bus.dp, L4);
      end
    end
    tick();
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1111, L_OFF}) begin
      n_errors++;
      $display("FAIL slot_dead: an=%b seg=%h, expected an=1111 seg=7f", bus.an, bus.seg);
    end
    tick();
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1101, L3}) begin
      n_errors++;
      $display("FAIL release_digit1: an=%b seg=%h, expected an=1101 seg=%h", bus.an, bus.seg, L3);
    end
  endtask

  task automatic test_snapshot();
    bus.digits_in = 16'h5959;
    bus.blank_lz  = 1'b0;
    reset_dut();
    goto(2);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1110, L9}) begin
      n_errors++;
      $display("FAIL snap_d0: an=%b seg=%h, expected an=1110 seg=%h", bus.an, bus.seg, L9);
    end
    goto(7);
    bus.digits_in = 16'h0000;
    goto(10);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1011, L9}) begin
      n_errors++;
      $display("FAIL snap_d2_old: an=%b seg=%h, expected an=1011 seg=%h", bus.an, bus.seg, L9);
    end
    goto(14);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b0111, L5}) begin
      n_errors++;
      $display("FAIL snap_d3_old: an=%b seg=%h, expected an=0111 seg=%h", bus.an, bus.seg, L5);
    end
    goto(18);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1110, L0}) begin
      n_errors++;
      $display("FAIL snap_d0_new: an=%b seg=%h, expected an=1110 seg=%h", bus.an, bus.seg, L0);
    end
    goto(30);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b0111, L0}) begin
      n_errors++;
      $display("FAIL snap_d3_new: an=%b seg=%h, expected an=0111 seg=%h", bus.an, bus.seg, L0);
    end
  endtask

  task automatic test_blanking();
    bus.digits_in = 16'h0007;
    bus.blank_lz  = 1'b1;
    reset_dut();
    goto(2);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1110, L7}) begin
      n_errors++;
      $display("FAIL blank_d0: an=%b seg=%h, expected an=1110 seg=%h", bus.an, bus.seg, L7);
    end
    for (int d = 1; d < 4; d++) begin
      goto(4 * d + 2);
      n_checks++;
      if ({bus.an, bus.seg} !== {~(4'b0001 << d), L_OFF}) begin
        n_errors++;
        $display("FAIL blank_d%0d: an=%b seg=%h, expected an=%b seg=7f", d, bus.an, bus.seg, ~(4'b0001 << d));
      end
    end
    bus.blank_lz = 1'b0;
    goto(22);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1101, L0}) begin
      n_errors++;
      $display("FAIL noblank_d1: an=%b seg=%h, expected an=1101 seg=%h", bus.an, bus.seg, L0);
    end
    goto(30);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b0111, L0}) begin
      n_errors++;
      $display("FAIL noblank_d3: an=%b seg=%h, expected an=0111 seg=%h", bus.an, bus.seg, L0);
    end
    bus.digits_in = 16'h0000;
    bus.blank_lz  = 1'b1;
    goto(34);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1110, L0}) begin
      n_errors++;
      $display("FAIL zero_d0: an=%b seg=%h, expected an=1110 seg=%h", bus.an, bus.seg, L0);
    end
    goto(38);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1101, L_OFF}) begin
      n_errors++;
      $display("FAIL zero_d1: an=%b seg=%h, expected an=1101 seg=7f", bus.an, bus.seg);
    end
  endtask

  task automatic test_invalid();
    bus.digits_in = 16'h00A3;
    bus.blank_lz  = 1'b0;
    reset_dut();
    goto(2);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1110, L3}) begin
      n_errors++;
      $display("FAIL inv_d0: an=%b seg=%h, expected an=1110 seg=%h", bus.an, bus.seg, L3);
    end
    goto(6);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1101, L_DASH}) begin
      n_errors++;
      $display("FAIL inv_d1_dash: an=%b seg=%b, expected an=1101 seg=0111111", bus.an, bus.seg);
    end
    goto(10);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1011, L0}) begin
      n_errors++;
      $display("FAIL inv_d2: an=%b seg=%h, expected an=1011 seg=%h", bus.an, bus.seg, L0);
    end
  endtask

  task automatic test_blink();
    bus.digits_in = 16'h1234;
    bus.blank_lz  = 1'b0;
    reset_dut();
    goto(1);
    bus.sec_tick = 1'b1;
    tick();
    bus.sec_tick = 1'b0;
    goto(6);
    n_checks++;
    if ({bus.an, bus.dp} !== {4'b1101, 1'b1}) begin
      n_errors++;
      $display("FAIL blink1_d1: an=%b dp=%b, expected an=1101 dp=1", bus.an, bus.dp);
    end
    goto(9);
    n_checks++;
    if ({bus.an, bus.dp} !== {4'b1111, 1'b1}) begin
      n_errors++;
      $display("FAIL blink1_dead: an=%b dp=%b, expected an=1111 dp=1", bus.an, bus.dp);
    end
    for (int i = 10; i <= 12; i++) begin
      goto(i);
      n_checks++;
      if ({bus.an, bus.dp, bus.seg} !== {4'b1011, 1'b0, L2}) begin
        n_errors++;
        $display("FAIL blink1_d2[k=%0d]: an=%b dp=%b seg=%h, expected an=1011 dp=0 seg=%h", i, bus.an, bus.dp, bus.seg, L2);
      end
    end
    goto(14);
    n_checks++;
    if ({bus.an, bus.dp} !== {4'b0111, 1'b1}) begin
      n_errors++;
      $display("FAIL blink1_d3: an=%b dp=%b, expected an=0111 dp=1", bus.an, bus.dp);
    end
    // Second pulse lands on the slot-wrap edge (k=16).
    goto(15);
    bus.sec_tick = 1'b1;
    tick();
    bus.sec_tick = 1'b0;
    goto(26);
    n_checks++;
    if ({bus.an, bus.dp} !== {4'b1011, 1'b1}) begin
      n_errors++;
      $display("FAIL blink2_d2: an=%b dp=%b, expected an=1011 dp=1", bus.an, bus.dp);
    end
    // Third pulse lands on the frame-snapshot edge (k=33).
    goto(32);
    bus.sec_tick = 1'b1;
    tick();
    bus.sec_tick = 1'b0;
    goto(38);
    n_checks++;
    if ({bus.an, bus.dp} !== {4'b1101, 1'b1}) begin
      n_errors++;
      $display("FAIL blink3_d1: an=%b dp=%b, expected an=1101 dp=1", bus.an, bus.dp);
    end
    goto(42);
    n_checks++;
    if ({bus.an, bus.dp} !== {4'b1011, 1'b0}) begin
      n_errors++;
      $display("FAIL blink3_d2: an=%b dp=%b, expected an=1011 dp=0", bus.an, bus.dp);
    end
  endtask

  task automatic test_mid_reset();
    bus.digits_in = 16'h1234;
    bus.blank_lz  = 1'b0;
    reset_dut();
    goto(10);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1011, L2}) begin
      n_errors++;
      $display("FAIL mid_pre_d2: an=%b seg=%h, expected an=1011 seg=%h", bus.an, bus.seg, L2);
    end
    bus.digits_in = 16'h8765;
    goto(11);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.an, bus.seg, bus.dp} !== {4'b1111, L_OFF, 1'b1}) begin
      n_errors++;
      $display("FAIL mid_reset: an=%b seg=%h dp=%b, expected an=1111 seg=7f dp=1", bus.an, bus.seg, bus.dp);
    end
    rst = 1'b1;
    k = 0;
    tick();
    n_checks++;
    if (bus.an !== 4'b1111) begin
      n_errors++;
      $display("FAIL mid_release_dead: an=%b, expected an=1111", bus.an);
    end
    tick();
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1110, L5}) begin
      n_errors++;
      $display("FAIL mid_restart_d0: an=%b seg=%h, expected an=1110 seg=%h", bus.an, bus.seg, L5);
    end
    goto(6);
    n_checks++;
    if ({bus.an, bus.seg} !== {4'b1101, L6}) begin
      n_errors++;
      $display("FAIL mid_restart_d1: an=%b seg=%h, expected an=1101 seg=%h", bus.an, bus.seg, L6);
    end
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_blanking();
    test_invalid();
    test_blink();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
